// File: rtl/hpipe_sync_pkg.sv
// ---------------------------------------------------------------------------
// hpipe_pkg
// Shared types and helpers for the hpipe_sync bundled-data buffer.
//   in_state_t   : input-side four-phase handshake states
//   out_state_t  : output-side four-phase handshake states
//   SYNC_STAGES  : depth of the optional r_i / a_o synchronisers
//   cnt_w()      : occupancy counter width for a given depth
//   ptr_w()      : read/write pointer width for a given depth
// ---------------------------------------------------------------------------
package hpipe_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_SETUP = 2'd1,
    OUT_REQ   = 2'd2,
    OUT_RTZ   = 2'd3
  } out_state_t;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry buffer still needs a 1-bit pointer to keep ports legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hpipe_sync_mem.sv
// ---------------------------------------------------------------------------
// hpipe_sync_mem
// DEPTH x N register array backing the hpipe_sync buffer. One synchronous
// write port, one asynchronous read port. Storage is not reset: an entry is
// only ever read after it has been written, so its power-up value is unseen.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address (AW bits, always < DEPTH)
//   wdata in  write data (N bits)
//   raddr in  read address (AW bits, always < DEPTH)
//   rdata out read data (N bits), combinational from raddr
// ---------------------------------------------------------------------------
module hpipe_sync_mem #(
  parameter int N     = 1,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/hpipe_sync.sv
// ---------------------------------------------------------------------------
// hpipe_sync
// DEPTH-entry, N-bit bundled-data buffer with a four-phase return-to-zero
// req/ack handshake on both sides. Bridges self-timed segments into and out
// of the clk domain, reports occupancy, and holds d_o stable for SETUP
// cycles before raising r_o.
//
// Ports:
//   clk   in  clock, rising-edge
//   rst   in  synchronous reset, active-high
//   r_i   in  input request
//   a_i   out input acknowledge (registered)
//   d_i   in  input data, valid while r_i=1
//   r_o   out output request (registered)
//   a_o   in  output acknowledge from consumer
//   d_o   out output data (registered)
//   count out occupancy, 0..DEPTH
//
// Build option:
//   HPIPE_SYNC_INSYNC_EN  when defined, r_i and a_o pass through a
//                         SYNC_STAGES-flop synchroniser before the FSMs,
//                         adding that many cycles to every handshake edge.
//
// Input FSM
//   state     | meaning
//   IN_IDLE   | waiting for r_i with room available; a_i=0
//   IN_ACK    | word captured, a_i=1, waiting for r_i to return to zero
//
// Output FSM
//   state     | meaning
//   OUT_IDLE  | nothing presented; load d_o from the head entry when count>0
//   OUT_SETUP | d_o stable, r_o=0, counting down the setup time
//   OUT_REQ   | r_o=1, waiting for a_o; pop on a_o
//   OUT_RTZ   | r_o=0, waiting for a_o to return to zero
// ---------------------------------------------------------------------------
module hpipe_sync
  import hpipe_pkg::*;
#(
  parameter int N        = 1,
  parameter int DEPTH    = 2,
  parameter bit RdataVal = 1'b0,
  parameter int SETUP    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r_i,
  output logic                      a_i,
  input  logic [N-1:0]              d_i,
  output logic                      r_o,
  input  logic                      a_o,
  output logic [N-1:0]              d_o,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int SW = (SETUP > 1) ? $clog2(SETUP) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [SW-1:0] SETUP_LD = SW'(SETUP - 1);

  logic             w_r_i;
  logic             w_a_o;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;
  logic [N-1:0]     w_rdata;

  in_state_t        r_in_state;
  out_state_t       r_out_state;
  logic             r_a_i;
  logic             r_r_o;
  logic [N-1:0]     r_d_o;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_setup_cnt;

  // -------------------------------------------------------------------------
  // Handshake input conditioning
  // -------------------------------------------------------------------------
`ifdef HPIPE_SYNC_INSYNC_EN
  logic [SYNC_STAGES-1:0] r_sync_ri;
  logic [SYNC_STAGES-1:0] r_sync_ao;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_ri <= '0;
      r_sync_ao <= '0;
    end else begin
      r_sync_ri <= {r_sync_ri[SYNC_STAGES-2:0], r_i};
      r_sync_ao <= {r_sync_ao[SYNC_STAGES-2:0], a_o};
    end
  end

  assign w_r_i = r_sync_ri[SYNC_STAGES-1];
  assign w_a_o = r_sync_ao[SYNC_STAGES-1];
`else
  assign w_r_i = r_i;
  assign w_a_o = a_o;
`endif

  // -------------------------------------------------------------------------
  // Push / pop qualifiers. The full check uses the registered count only, so
  // a push arriving at full alongside a pop is taken on the following cycle.
  // -------------------------------------------------------------------------
  assign w_push = (r_in_state == IN_IDLE) && w_r_i && (r_count < DEPTH_C);
  assign w_pop  = (r_out_state == OUT_REQ) && w_a_o;

  assign w_wptr_nxt = (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
  assign w_rptr_nxt = (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);

  hpipe_sync_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (d_i),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  // -------------------------------------------------------------------------
  // Input FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_state <= IN_IDLE;
      r_a_i      <= 1'b0;
      r_wptr     <= '0;
    end else begin
      case (r_in_state)
        IN_IDLE: begin
          if (w_push) begin
            r_wptr     <= w_wptr_nxt;
            r_a_i      <= 1'b1;
            r_in_state <= IN_ACK;
          end
        end
        IN_ACK: begin
          if (!w_r_i) begin
            r_a_i      <= 1'b0;
            r_in_state <= IN_IDLE;
          end
        end
        default: begin
          r_a_i      <= 1'b0;
          r_in_state <= IN_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output FSM. d_o is only written on the OUT_IDLE -> OUT_SETUP load, so it
  // stays put through the whole four-phase cycle of the presented word.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= OUT_IDLE;
      r_r_o       <= 1'b0;
      r_d_o       <= {N{RdataVal}};
      r_rptr      <= '0;
      r_setup_cnt <= '0;
    end else begin
      case (r_out_state)
        OUT_IDLE: begin
          if (r_count != '0) begin
            r_d_o       <= w_rdata;
            r_setup_cnt <= SETUP_LD;
            r_out_state <= OUT_SETUP;
          end
        end
        OUT_SETUP: begin
          if (r_setup_cnt == '0) begin
            r_r_o       <= 1'b1;
            r_out_state <= OUT_REQ;
          end else begin
            r_setup_cnt <= r_setup_cnt - SW'(1);
          end
        end
        OUT_REQ: begin
          if (w_pop) begin
            r_rptr      <= w_rptr_nxt;
            r_r_o       <= 1'b0;
            r_out_state <= OUT_RTZ;
          end
        end
        OUT_RTZ: begin
          if (!w_a_o) begin
            r_out_state <= OUT_IDLE;
          end
        end
        default: begin
          r_r_o       <= 1'b0;
          r_out_state <= OUT_IDLE;
        end
      endcase
    end
  end

  assign a_i   = r_a_i;
  assign r_o   = r_r_o;
  assign d_o   = r_d_o;
  assign count = r_count;

  // -------------------------------------------------------------------------
  // Protocol checks. The FSMs simply ignore these violations; the checks make
  // them visible in simulation. The cycle right after reset is excluded since
  // an abandoned handshake legitimately drops r_i with a_i already cleared.
  // -------------------------------------------------------------------------
  a_ri_dropped_early: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && $fell(w_r_i)) |-> r_a_i);

  a_ao_outside_req: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && $rose(w_a_o)) |-> (r_out_state == OUT_REQ));

endmodule

// File: tb/tb_hpipe_sync.sv
module tb_hpipe_sync;

`ifdef HPIPE_SYNC_INSYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int TMO = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] r_i;
  logic [2:0] a_o;
  logic [7:0] d_i [3];
  wire  [2:0] a_i;
  wire  [2:0] r_o;
  wire  [7:0] d_o0, d_o1, d_o2;
  wire  [2:0] count0;
  wire  [1:0] count1, count2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb [3][$];

  // u0: DEPTH=4, SETUP=1   u1: DEPTH=3, d_o resets to all ones   u2: DEPTH=2, SETUP=3
  hpipe_sync #(.N(8), .DEPTH(4), .RdataVal(1'b0), .SETUP(1)) u0 (
    .clk(clk), .rst(rst[0]), .r_i(r_i[0]), .a_i(a_i[0]), .d_i(d_i[0]),
    .r_o(r_o[0]), .a_o(a_o[0]), .d_o(d_o0), .count(count0));
  hpipe_sync #(.N(8), .DEPTH(3), .RdataVal(1'b1), .SETUP(1)) u1 (
    .clk(clk), .rst(rst[1]), .r_i(r_i[1]), .a_i(a_i[1]), .d_i(d_i[1]),
    .r_o(r_o[1]), .a_o(a_o[1]), .d_o(d_o1), .count(count1));
  hpipe_sync #(.N(8), .DEPTH(2), .RdataVal(1'b0), .SETUP(3)) u2 (
    .clk(clk), .rst(rst[2]), .r_i(r_i[2]), .a_i(a_i[2]), .d_i(d_i[2]),
    .r_o(r_o[2]), .a_o(a_o[2]), .d_o(d_o2), .count(count2));

  function automatic logic [7:0] get_do(input int p);
    case (p)
      0:       return d_o0;
      1:       return d_o1;
      default: return d_o2;
    endcase
  endfunction

  function automatic int get_cnt(input int p);
    case (p)
      0:       return int'(count0);
      1:       return int'(count1);
      default: return int'(count2);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Producer side: one full four-phase cycle; the word enters the scoreboard
  // once the buffer acknowledges it.
  task automatic send(input int p, input logic [7:0] data);
    int n;
    r_i[p] = 1'b1;
    d_i[p] = data;
    n = 0;
    while (a_i[p] !== 1'b1 && n < TMO) begin tick(); n++; end
    if (a_i[p] !== 1'b1) begin
      check("ack_rise_timeout", {31'b0, a_i[p]}, 1);
      r_i[p] = 1'b0;
      return;
    end
    sb[p].push_back(data);
    r_i[p] = 1'b0;
    n = 0;
    while (a_i[p] !== 1'b0 && n < TMO) begin tick(); n++; end
    if (a_i[p] !== 1'b0) check("ack_fall_timeout", {31'b0, a_i[p]}, 0);
  endtask

  // Consumer side: wait for r_o, compare against the scoreboard, complete RTZ.
  task automatic recv(input int p);
    int n;
    logic [7:0] exp;
    n = 0;
    while (r_o[p] !== 1'b1 && n < TMO) begin tick(); n++; end
    if (r_o[p] !== 1'b1) begin
      check("req_rise_timeout", {31'b0, r_o[p]}, 1);
      return;
    end
    if (sb[p].size() == 0) begin
      check("unexpected_word", {24'b0, get_do(p)}, 32'hFFFF_FFFF);
    end else begin
      exp = sb[p].pop_front();
      check("data_order", {24'b0, get_do(p)}, {24'b0, exp});
    end
    a_o[p] = 1'b1;
    n = 0;
    while (r_o[p] !== 1'b0 && n < TMO) begin tick(); n++; end
    if (r_o[p] !== 1'b0) check("req_fall_timeout", {31'b0, r_o[p]}, 0);
    a_o[p] = 1'b0;
  endtask

  // Cycle-exact single-word handshake on an empty buffer.
  task automatic hs_timing(input int p, input logic [7:0] data, input int setup);
    int t_ai, t_aif, t_d, t_ro, t_rof, cnt_ai;
    bit chg;
    t_ai = -1; t_aif = -1; t_d = -1; t_ro = -1; t_rof = -1; cnt_ai = -1; chg = 1'b0;
    r_i[p] = 1'b1;
    d_i[p] = data;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t_ai < 0 && a_i[p] === 1'b1) begin
        t_ai = t; cnt_ai = get_cnt(p); r_i[p] = 1'b0;
      end else if (t_ai >= 0 && t_aif < 0 && a_i[p] === 1'b0) begin
        t_aif = t;
      end
      if (t_d < 0 && get_do(p) === data) t_d = t;
      else if (t_d >= 0 && get_do(p) !== data) chg = 1'b1;
      if (t_ro < 0 && r_o[p] === 1'b1) begin
        t_ro = t; a_o[p] = 1'b1;
      end else if (t_ro >= 0 && t_rof < 0 && r_o[p] === 1'b0) begin
        t_rof = t; a_o[p] = 1'b0;
      end
    end
    r_i[p] = 1'b0;
    a_o[p] = 1'b0;
    check("hs_ai_rise_cycle",  t_ai,      1 + L);
    check("hs_count_at_ack",   cnt_ai,    1);
    check("hs_ai_fall_cycle",  t_aif,     1 + L + 1 + L);
    check("hs_do_load_cycle",  t_d,       2 + L);
    check("hs_ro_rise_cycle",  t_ro,      2 + setup + L);
    check("hs_do_setup_span",  t_ro - t_d, setup);
    check("hs_ro_fall_cycle",  t_rof,     2 + setup + L + 1 + L);
    check("hs_do_stable",      {31'b0, chg}, 0);
    check("hs_count_drained",  get_cnt(p), 0);
  endtask

  typedef struct {
    int         dut;
    int         nwords;
    int         stall;
    logic [7:0] base;
    int         exp_peak;   // -1: not checked
    bit         exp_held;   // producer must be stalled with a_i=0 after the stall
  } vec_t;

  vec_t vec [6];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    vec[0] = '{dut: 0, nwords: 6,  stall: 60, base: 8'h01, exp_peak: 4,  exp_held: 1'b1};
    vec[1] = '{dut: 1, nwords: 10, stall: 0,  base: 8'h10, exp_peak: -1, exp_held: 1'b0};
    vec[2] = '{dut: 1, nwords: 10, stall: 50, base: 8'h40, exp_peak: 3,  exp_held: 1'b1};
    vec[3] = '{dut: 2, nwords: 5,  stall: 0,  base: 8'h80, exp_peak: -1, exp_held: 1'b0};
    vec[4] = '{dut: 2, nwords: 4,  stall: 60, base: 8'hC0, exp_peak: 2,  exp_held: 1'b1};
    vec[5] = '{dut: 0, nwords: 3,  stall: 40, base: 8'hE0, exp_peak: 3,  exp_held: 1'b0};

    rst = 3'b111;
    r_i = 3'b000;
    a_o = 3'b000;
    for (int p = 0; p < 3; p++) d_i[p] = 8'h00;
    tick();
    tick();
    for (int p = 0; p < 3; p++) begin
      check("rst_a_i",   {31'b0, a_i[p]}, 0);
      check("rst_r_o",   {31'b0, r_o[p]}, 0);
      check("rst_count", get_cnt(p), 0);
      check("rst_d_o",   {24'b0, get_do(p)}, (p == 1) ? 32'hFF : 32'h00);
    end
    rst = 3'b000;
    tick();

    // Single word, SETUP=1, then SETUP=3.
    hs_timing(0, 8'hA5, 1);
    hs_timing(2, 8'h5A, 3);

    // Reset while both handshakes are mid-flight.
    r_i[0] = 1'b1;
    d_i[0] = 8'h3C;
    n = 0;
    while (!(a_i[0] === 1'b1 && r_o[0] === 1'b1) && n < TMO) begin tick(); n++; end
    check("mid_hs_ai_ro", {30'b0, a_i[0], r_o[0]}, 32'h3);
    check("mid_hs_d_o", {24'b0, d_o0}, 32'h3C);
    rst[0] = 1'b1;
    r_i[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    check("mid_rst_a_i",   {31'b0, a_i[0]}, 0);
    check("mid_rst_r_o",   {31'b0, r_o[0]}, 0);
    check("mid_rst_count", get_cnt(0), 0);
    check("mid_rst_d_o",   {24'b0, d_o0}, 32'h00);
    repeat (6) tick();
    check("mid_rst_no_entry", {31'b0, r_o[0]}, 0);

    // Table-driven burst / backpressure / wrap runs.
    for (int i = 0; i < 6; i++) begin
      fork
        begin
          for (int w = 0; w < vec[i].nwords; w++) send(vec[i].dut, vec[i].base + 8'(w));
        end
        begin
          repeat (vec[i].stall) tick();
          if (vec[i].exp_peak >= 0) check("burst_peak_count", get_cnt(vec[i].dut), vec[i].exp_peak);
          if (vec[i].exp_held) check("burst_full_no_ack", {31'b0, a_i[vec[i].dut]}, 0);
          for (int w = 0; w < vec[i].nwords; w++) recv(vec[i].dut);
        end
      join
      check("burst_drain_count", get_cnt(vec[i].dut), 0);
      check("burst_sb_empty", sb[vec[i].dut].size(), 0);
    end

    // Push and pop in the same cycle at count=2.
    send(0, 8'h71);
    send(0, 8'h72);
    n = 0;
    while (r_o[0] !== 1'b1 && n < TMO) begin tick(); n++; end
    check("pp_pre_count", get_cnt(0), 2);
    check("pp_pre_r_o", {31'b0, r_o[0]}, 1);
    check("pp_head", {24'b0, d_o0}, {24'b0, sb[0].pop_front()});
    r_i[0] = 1'b1;
    d_i[0] = 8'h73;
    a_o[0] = 1'b1;
    repeat (1 + L) tick();
    check("pp_count_same", get_cnt(0), 2);
    check("pp_a_i", {31'b0, a_i[0]}, 1);
    check("pp_r_o", {31'b0, r_o[0]}, 0);
    sb[0].push_back(8'h73);
    r_i[0] = 1'b0;
    a_o[0] = 1'b0;
    n = 0;
    while (a_i[0] !== 1'b0 && n < TMO) begin tick(); n++; end
    recv(0);
    recv(0);
    check("pp_drain_count", get_cnt(0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
